// File: rtl/uart_tx_io.sv
// uart_tx_io: memory-mapped UART transmitter (8N1, LSB first) with a byte FIFO and a STATUS word.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit between data bit 7 and stop.
module uart_tx_io #(
    parameter int CLK_HZ = 23000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        UARTCtrl,
    input  logic        ioWrite,
    input  logic        ioRead,
    input  logic [1:0]  uartAddr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        tx
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
    localparam logic [2:0] PARITY = 3'd4;
    logic [2:0] state;
    logic       parity_bit;
`else
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;
    logic [1:0] state;
`endif

    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          overflow;
    logic          empty;
    logic          full;
    logic          tx_busy;
    logic          push_req;
    logic          push_ok;
    logic          stat_rd;
    logic          at_last;
    logic          pop;
    logic [7:0]    head;
    logic          unused_hi;

    assign unused_hi = ^write_data[15:8];

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign tx_busy  = (state != IDLE);
    assign push_req = UARTCtrl && ioWrite && (uartAddr == 2'b00);
    assign push_ok  = push_req && !full;
    assign stat_rd  = UARTCtrl && ioRead && (uartAddr == 2'b10);
    assign at_last  = (cnt == CNT_LAST);
    assign head     = mem[rd_ptr[AW-1:0]];
    // A stop bit that ends with data waiting chains straight into the next start bit.
    assign pop      = !empty && ((state == IDLE) || ((state == STOP) && at_last));

    always_comb begin
        read_data = '0;
        if (stat_rd)
            read_data = {12'b0, overflow, tx_busy, full, empty};
    end

    always_ff @(posedge clock) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= write_data[7:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_ONE;

            // A rejected push in the same cycle as a STATUS read keeps the flag set.
            if (push_req && full)
                overflow <= 1'b1;
            else if (stat_rd)
                overflow <= 1'b0;

            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                shift  <= head;
                tx     <= 1'b0;
                cnt    <= '0;
                state  <= START;
`ifdef UART_TX_PARITY_EN
                parity_bit <= ^head;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        tx <= 1'b1;
                    end
                    START: begin
                        if (at_last) begin
                            cnt     <= '0;
                            tx      <= shift[0];
                            bit_idx <= '0;
                            state   <= DATA;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    DATA: begin
                        if (at_last) begin
                            cnt <= '0;
                            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                                tx    <= parity_bit;
                                state <= PARITY;
`else
                                tx    <= 1'b1;
                                state <= STOP;
`endif
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                tx      <= shift[bit_idx + 3'd1];
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        if (at_last) begin
                            cnt   <= '0;
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
`endif
                    STOP: begin
                        if (at_last) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_io.sv
// tb_uart_tx_io: scoreboard bench for uart_tx_io at DIV=10; a line monitor decodes frames from tx.
module tb_uart_tx_io;
    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11 * DIV;
`else
    localparam int FRAME = 10 * DIV;
`endif

    logic        clock;
    logic        reset;
    logic        UARTCtrl;
    logic        ioWrite;
    logic        ioRead;
    logic [1:0]  uartAddr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        tx;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int store_edge = 0;

    logic [7:0] sb[$];
    int mon_starts[$];
    int mon_ends[$];
    logic mon_last_par = 1'b0;

    uart_tx_io #(.CLK_HZ(1000000), .BAUD(100000), .DEPTH(8)) dut (
        .clock(clock), .reset(reset), .UARTCtrl(UARTCtrl), .ioWrite(ioWrite),
        .ioRead(ioRead), .uartAddr(uartAddr), .write_data(write_data),
        .read_data(read_data), .tx(tx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // Samples n negedges; v is the first sample, glitch flags any later sample that differs.
    task automatic slot(input int n, output logic v, output bit ab, output bit glitch);
        ab = 0; glitch = 0; v = 1'bx;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (reset) begin ab = 1; return; end
            if (i == 0) v = tx;
            else if (tx !== v) glitch = 1;
        end
    endtask

    logic       m_v;
    bit         m_ab, m_g, m_bad;
    logic [7:0] m_byte, m_exp;
    logic       m_par;

    always begin : monitor
        @(negedge clock);
        if (!reset && tx === 1'b0) begin
            m_bad = 0; m_byte = '0; m_par = 1'b0;
            mon_starts.push_back(cyc);
            slot(DIV - 1, m_v, m_ab, m_g);
            m_bad = m_bad | m_g | (m_v !== 1'b0);
            for (int k = 0; k < 8; k++) begin
                if (!m_ab) begin
                    slot(DIV, m_v, m_ab, m_g);
                    m_byte[k] = m_v;
                    m_bad = m_bad | m_g;
                end
            end
`ifdef UART_TX_PARITY_EN
            if (!m_ab) begin
                slot(DIV, m_v, m_ab, m_g);
                m_par = m_v;
                m_bad = m_bad | m_g;
            end
`endif
            if (!m_ab) begin
                slot(DIV, m_v, m_ab, m_g);
                m_bad = m_bad | m_g | (m_v !== 1'b1);
            end
            if (!m_ab) begin
                mon_ends.push_back(cyc);
                mon_last_par = m_par;
                tests++;
                if (m_bad) begin
                    fails++;
                    $display("FAIL framing: frame starting at cycle %0d has bad start/stop or unstable bit, required clean 8N1 slots", mon_starts[$]);
                end
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_frame: got byte %02h, required no frame", m_byte);
                end else begin
                    m_exp = sb.pop_front();
                    if (m_byte !== m_exp) begin
                        fails++;
                        $display("FAIL frame_data: got %02h, required %02h", m_byte, m_exp);
                    end
`ifdef UART_TX_PARITY_EN
                    tests++;
                    if (m_par !== ^m_exp) begin
                        fails++;
                        $display("FAIL parity_bit: got %b, required %b", m_par, ^m_exp);
                    end
`endif
                end
            end
        end
    end

    task automatic do_store(input logic ctrl, input logic [1:0] addr, input logic [7:0] d, input bit expect_frame);
        @(negedge clock);
        UARTCtrl = ctrl; ioWrite = 1'b1; uartAddr = addr; write_data = {8'hEE, d};
        @(posedge clock); #1;
        store_edge = cyc;
        if (expect_frame) sb.push_back(d);
        UARTCtrl = 1'b0; ioWrite = 1'b0; uartAddr = 2'b00;
    endtask

    task automatic do_read(input logic [1:0] addr, output logic [15:0] v);
        @(negedge clock);
        UARTCtrl = 1'b1; ioRead = 1'b1; uartAddr = addr;
        #1 v = read_data;
        @(posedge clock); #1;
        UARTCtrl = 1'b0; ioRead = 1'b0; uartAddr = 2'b00;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clock);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d bytes still expected, required 0", sb.size());
        end
    endtask

    task automatic test_reset;
        logic [15:0] v;
        reset = 1'b1; UARTCtrl = 1'b0; ioWrite = 1'b0; ioRead = 1'b0;
        uartAddr = 2'b00; write_data = '0;
        repeat (3) @(posedge clock);
        #1;
        tests++;
        if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b, required 1", tx); end
        @(negedge clock); #1 reset = 1'b0;
        #1;
        tests++;
        if (read_data !== 16'h0000) begin fails++; $display("FAIL reset_read_idle: got %04h, required 0000", read_data); end
        do_read(2'b10, v);
        tests++;
        if (v !== 16'h0001) begin fails++; $display("FAIL reset_status: got %04h, required 0001", v); end
    endtask

    task automatic test_single;
        logic [15:0] v;
        int base;
        base = mon_starts.size();
        do_store(1'b1, 2'b00, 8'h55, 1);
        repeat (30) @(posedge clock);
        do_read(2'b10, v);
        tests++;
        if (v !== 16'h0005) begin fails++; $display("FAIL status_busy: got %04h, required 0005", v); end
        do_read(2'b00, v);
        tests++;
        if (v !== 16'h0000) begin fails++; $display("FAIL txdata_read: got %04h, required 0000", v); end
        wait_drain(200);
        tests++;
        if (mon_starts.size() != base + 1 || mon_starts[base] - store_edge != 1) begin
            fails++;
            $display("FAIL start_latency: got frames=%0d, required 1 frame starting 1 cycle after store", mon_starts.size() - base);
        end else begin
            tests++;
            if (mon_ends[base] - mon_starts[base] + 1 != FRAME) begin
                fails++;
                $display("FAIL frame_length: got %0d cycles, required %0d", mon_ends[base] - mon_starts[base] + 1, FRAME);
            end
        end
        do_read(2'b10, v);
        tests++;
        if (v !== 16'h0001) begin fails++; $display("FAIL status_after: got %04h, required 0001", v); end
    endtask

    task automatic test_back_to_back;
        int base;
        base = mon_starts.size();
        do_store(1'b1, 2'b00, 8'h41, 1);
        do_store(1'b1, 2'b00, 8'h42, 1);
        wait_drain(300);
        tests++;
        if (mon_ends.size() < base + 2) begin
            fails++;
            $display("FAIL b2b_frames: got %0d frames, required 2", mon_ends.size() - base);
        end else begin
            if (mon_starts[base + 1] != mon_ends[base] + 1) begin
                fails++;
                $display("FAIL b2b_gap: got %0d idle cycles, required 0", mon_starts[base + 1] - mon_ends[base] - 1);
            end
            tests++;
            if (mon_ends[base + 1] - mon_starts[base] + 1 != 2 * FRAME) begin
                fails++;
                $display("FAIL b2b_total: got %0d cycles, required %0d", mon_ends[base + 1] - mon_starts[base] + 1, 2 * FRAME);
            end
        end
    endtask

    task automatic test_overflow;
        logic [15:0] v;
        for (int i = 0; i < 9; i++) do_store(1'b1, 2'b00, 8'h30 + 8'(i), 1);
        for (int i = 0; i < 3; i++) do_store(1'b1, 2'b00, 8'hF0 + 8'(i), 0);
        do_read(2'b10, v);
        tests++;
        if (v !== 16'h000E) begin fails++; $display("FAIL overflow_status: got %04h, required 000E", v); end
        do_read(2'b10, v);
        tests++;
        if (v !== 16'h0006) begin fails++; $display("FAIL overflow_clear: got %04h, required 0006", v); end
        wait_drain(12 * FRAME);
        repeat (2) @(posedge clock);
        do_read(2'b10, v);
        tests++;
        if (v !== 16'h0001) begin fails++; $display("FAIL overflow_drained: got %04h, required 0001", v); end
    endtask

    task automatic test_ignored_stores;
        logic [15:0] v;
        int base;
        base = mon_starts.size();
        do_store(1'b0, 2'b00, 8'h99, 0);
        do_store(1'b1, 2'b10, 8'h98, 0);
        repeat (50) @(posedge clock);
        tests++;
        if (mon_starts.size() != base) begin fails++; $display("FAIL ignored_store: got %0d frames, required 0", mon_starts.size() - base); end
        do_read(2'b10, v);
        tests++;
        if (v !== 16'h0001) begin fails++; $display("FAIL ignored_status: got %04h, required 0001", v); end
    endtask

    task automatic test_reset_midframe;
        logic [15:0] v;
        do_store(1'b1, 2'b00, 8'hA5, 1);
        do_store(1'b1, 2'b00, 8'h11, 1);
        do_store(1'b1, 2'b00, 8'h22, 1);
        do_store(1'b1, 2'b00, 8'h33, 1);
        // Store of 0xA5 at edge N-3; bit 3 spans edges N-2+40 .. N-2+49.
        repeat (42) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        tests++;
        if (tx !== 1'b1) begin fails++; $display("FAIL reset_async_tx: got %b, required 1", tx); end
        repeat (2) @(posedge clock);
        sb.delete();
        @(negedge clock); #1 reset = 1'b0;
        mon_starts.delete();
        mon_ends.delete();
        do_read(2'b10, v);
        tests++;
        if (v !== 16'h0001) begin fails++; $display("FAIL reset_mid_status: got %04h, required 0001", v); end
        repeat (3 * FRAME) @(posedge clock);
        tests++;
        if (mon_starts.size() != 0) begin fails++; $display("FAIL reset_no_frames: got %0d frames, required 0", mon_starts.size()); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        do_store(1'b1, 2'b00, 8'h07, 1);
        wait_drain(2 * FRAME);
        tests++;
        if (mon_last_par !== 1'b1) begin fails++; $display("FAIL parity_07: got %b, required 1", mon_last_par); end
        tests++;
        if (mon_ends[$] - mon_starts[$] + 1 != 110) begin
            fails++;
            $display("FAIL parity_length: got %0d, required 110", mon_ends[$] - mon_starts[$] + 1);
        end
        do_store(1'b1, 2'b00, 8'h03, 1);
        wait_drain(2 * FRAME);
        tests++;
        if (mon_last_par !== 1'b0) begin fails++; $display("FAIL parity_03: got %b, required 0", mon_last_par); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_ignored_stores();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
